// File: rtl/op_word_packer.sv
// Writer side of the 10-bit packed op-word format: raw or field-view writes
// into a small FIFO drained over a valid/ready stream.
module op_word_packer #(
  parameter int DEPTH  = 4,
  parameter bit SEQ_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_raw,
  input  logic [9:0]               in_data,
  input  logic [2:0]               in_op2,
  input  logic [2:0]               in_op5,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [9:0]               out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][9:0] mem;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [3:0]            seq;
  logic                  push, pop;
  logic [9:0]            wdata;
  logic [3:0]            tag;

  // in_ready depends on registered occupancy only: a full FIFO never
  // accepts, even when the head is being popped in the same cycle.
  assign in_ready  = (level < FULL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : 10'h000;

  assign tag   = SEQ_EN ? seq : 4'h0;
  assign wdata = in_raw ? in_data : {tag, in_op2, in_op5};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      seq    <= 4'h0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
        if (!in_raw) seq <= seq + 4'h1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_op_word_packer.sv
// Directed bench for op_word_packer (DEPTH=4, SEQ_EN=1).
module tb_op_word_packer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_raw;
  logic [9:0] in_data;
  logic [2:0] in_op2;
  logic [2:0] in_op5;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [2:0] level;

  int vectors;
  int miscompares;

  op_word_packer #(.DEPTH(4), .SEQ_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_raw(in_raw),
    .in_data(in_data), .in_op2(in_op2), .in_op5(in_op5),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic field(input logic [2:0] op2, input logic [2:0] op5);
    in_valid = 1'b1; in_raw = 1'b0; in_op2 = op2; in_op5 = op5;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    field(3'd5, 3'd2);
    step();
    rst = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (level !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
    vectors++;
    if (out_data !== 10'h000) begin miscompares++; $display("FAIL reset_out_data got %h want 000", out_data); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    field(3'd5, 3'd2);
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid got %b want 1", out_valid); end
    vectors++;
    if (out_data !== 10'h02A) begin miscompares++; $display("FAIL single_out_data got %h want 02A", out_data); end
    vectors++;
    if (level !== 3'd1) begin miscompares++; $display("FAIL single_level got %0d want 1", level); end
    step();
    vectors++;
    if (level !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_drain level %0d valid %b want 0 0", level, out_valid);
    end
  endtask

  task automatic test_tag_wrap();
    logic [9:0] exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      field(3'd1, 3'd1);
      step();
      exp = {4'(i), 3'd1, 3'd1};
      if (i == 6 && exp !== 10'h189) $display("note: tag table inconsistent");
      vectors++;
      if (out_data !== exp || level !== 3'd1) begin
        miscompares++; $display("FAIL tag_word%0d got %h lvl %0d want %h lvl 1", i, out_data, level, exp);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (level !== 3'd0) begin miscompares++; $display("FAIL tag_drain got %0d want 0", level); end
  endtask

  task automatic test_raw_interleave();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_raw = 1'b1; in_data = 10'h3FF; in_op2 = 3'd0; in_op5 = 3'd0;
    step();
    field(3'd7, 3'd0);
    vectors++;
    if (out_data !== 10'h3FF) begin miscompares++; $display("FAIL raw_word got %h want 3FF", out_data); end
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_data !== 10'h038) begin miscompares++; $display("FAIL raw_then_field got %h want 038", out_data); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      field(3'(i + 1), 3'(i + 2));
      vectors++;
      if (in_ready !== (i < 4)) begin
        miscompares++; $display("FAIL bp_in_ready%0d got %b want %b", i, in_ready, (i < 4));
      end
      step();
      vectors++;
      if (out_data !== 10'h00A) begin miscompares++; $display("FAIL bp_head%0d got %h want 00A", i, out_data); end
    end
    vectors++;
    if (level !== 3'd4) begin miscompares++; $display("FAIL bp_level_full got %0d want 4", level); end
    // Pop while full with the rejected write still presented: no push.
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (level !== 3'd3 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_one_pop level %0d rdy %b want 3 1", level, in_ready);
    end
    vectors++;
    if (out_data !== 10'h053) begin miscompares++; $display("FAIL bp_second got %h want 053", out_data); end
    out_ready = 1'b1;
    step();
    vectors++;
    if (out_data !== 10'h09C) begin miscompares++; $display("FAIL bp_third got %h want 09C", out_data); end
    step();
    vectors++;
    if (out_data !== 10'h0E5) begin miscompares++; $display("FAIL bp_fourth got %h want 0E5", out_data); end
    step();
    vectors++;
    if (level !== 3'd0 || out_data !== 10'h000) begin
      miscompares++; $display("FAIL bp_empty level %0d data %h want 0 000", level, out_data);
    end
    field(3'd0, 3'd0);
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_data !== 10'h100) begin miscompares++; $display("FAIL bp_seq_after got %h want 100", out_data); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      field(3'(i), 3'(7 - i));
      step();
      exp = {4'(i), 3'(i), 3'(7 - i)};
      vectors++;
      if (out_data !== exp || level !== 3'd1 || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL stream%0d got %h lvl %0d want %h lvl 1", i, out_data, level, exp);
      end
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (level !== 3'd0) begin miscompares++; $display("FAIL stream_drain got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      field(3'd2, 3'd3);
      step();
    end
    vectors++;
    if (level !== 3'd3) begin miscompares++; $display("FAIL mid_level got %0d want 3", level); end
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 3'd0 || out_data !== 10'h000) begin
      miscompares++; $display("FAIL mid_reset valid %b lvl %0d data %h want 0 0 000", out_valid, level, out_data);
    end
    out_ready = 1'b1;
    field(3'd1, 3'd1);
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_data !== 10'h009) begin miscompares++; $display("FAIL mid_tag0 got %h want 009", out_data); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; in_raw = 1'b0; in_data = '0;
    in_op2 = '0; in_op5 = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_tag_wrap();
    test_raw_interleave();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
